// File: rtl/vga_pixel_fifo_if.sv
// Writer-side valid/ready bundle for vga_pixel_fifo: RGB333 pixel plus
// start-of-frame tag. The master is the DMA/bus writer; the slave is the FIFO.
interface vga_pixel_fifo_if;
    logic       s_valid;
    logic       s_ready;
    logic [8:0] s_data;
    logic       s_sof;

    modport master (
        output s_valid,
        output s_data,
        output s_sof,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_sof,
        output s_ready
    );
endinterface

// File: rtl/vga_pixel_fifo.sv
// Frame-aligned RGB333 pixel FIFO feeding the VGA timing driver.
// Optional macro VGA_FIFO_STATS_EN adds underflow_cnt and sync_err_cnt outputs.
module vga_pixel_fifo #(
    parameter int         DEPTH       = 64,
    parameter int         H_ACTIVE    = 800,
    parameter int         V_ACTIVE    = 600,
    parameter logic [8:0] BLANK_COLOR = 9'h000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vga_pixel_fifo_if.slave          s,
    input  logic                     de_in,
    output logic [8:0]               color,
    output logic                     frame_req,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sync_err
`ifdef VGA_FIFO_STATS_EN
    ,
    output logic [15:0]              underflow_cnt,
    output logic [7:0]               sync_err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Storage and pointers
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Raster position and FSM
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    state_t        r_state;
    state_t        w_state_nxt;

    // Registered outputs
    logic [8:0]    r_color;
    logic          r_frame_req;
    logic          r_sync_err;

    // Combinational decisions
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [9:0]    w_head;
    logic          w_head_sof;
    logic [8:0]    w_head_data;
    logic          w_origin;
    logic          w_x_last;
    logic          w_y_last;
    logic [8:0]    w_color_nxt;
    logic          w_sync_err_nxt;
    logic          w_underflow;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == {LW{1'b0}});
    assign w_push      = s.s_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_sof  = w_head[9];
    assign w_head_data = w_head[8:0];
    assign w_x_last    = (r_x == XW'(H_ACTIVE - 1));
    assign w_y_last    = (r_y == YW'(V_ACTIVE - 1));
    assign w_origin    = (r_x == {XW{1'b0}}) && (r_y == {YW{1'b0}});

    assign s.s_ready   = !w_full;
    assign color       = r_color;
    assign frame_req   = r_frame_req;
    assign level       = r_level;
    assign sync_err    = r_sync_err;

    // Pixel storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s.s_sof, s.s_data};
        end
    end

    // Pointers and occupancy; a SYNC discard is an ordinary pop here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Raster position follows de_in alone, so it stays locked to the driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= {XW{1'b0}};
            r_y <= {YW{1'b0}};
        end else if (de_in) begin
            if (w_x_last) begin
                r_x <= {XW{1'b0}};
                r_y <= w_y_last ? {YW{1'b0}} : (r_y + YW'(1));
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pop decision and next colour
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_color_nxt    = BLANK_COLOR;
        w_sync_err_nxt = 1'b0;
        w_underflow    = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (!w_empty && !w_head_sof) begin
                    // Stale mid-frame data is flushed regardless of de_in
                    w_pop = 1'b1;
                end else if (de_in && w_origin && !w_empty) begin
                    w_pop       = 1'b1;
                    w_color_nxt = w_head_data;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pop = 1'b0;
                end
            end
            ST_RUN: begin
                if (de_in) begin
                    if (w_empty) begin
                        w_underflow = 1'b1;
                    end else if (w_head_sof && !w_origin) begin
                        // Keep the early sof pixel for the next (0,0)
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = ST_SYNC;
                    end else if (w_origin && !w_head_sof) begin
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = ST_SYNC;
                    end else begin
                        w_pop       = 1'b1;
                        w_color_nxt = w_head_data;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // Output registers: colour, frame request and sync error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color     <= BLANK_COLOR;
            r_frame_req <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_color     <= w_color_nxt;
            r_frame_req <= de_in && w_x_last && w_y_last;
            r_sync_err  <= w_sync_err_nxt;
        end
    end

`ifdef VGA_FIFO_STATS_EN
    logic [15:0] r_underflow_cnt;
    logic [7:0]  r_sync_err_cnt;

    assign underflow_cnt = r_underflow_cnt;
    assign sync_err_cnt  = r_sync_err_cnt;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow_cnt <= 16'h0000;
            r_sync_err_cnt  <= 8'h00;
        end else begin
            if (w_underflow && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'h0001;
            end
            if (w_sync_err_nxt && (r_sync_err_cnt != 8'hFF)) begin
                r_sync_err_cnt <= r_sync_err_cnt + 8'h01;
            end
        end
    end
`endif

endmodule
